// File: rtl/wrired_master.sv
// wrired_master: request/response initiator for the WriRed 1-bit register file.
// Sequences write, read and clear-all pin activity with fully registered outputs.
module wrired_master #(
    parameter int ADDR_W = 2,
    parameter int RD_LAT = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic [1:0]        REQ_OP,
    input  logic [ADDR_W-1:0] REQ_ADDR,
    input  logic              REQ_DATA,
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic              RSP_DATA,
    output logic              RSP_ERR,
    output logic [ADDR_W-1:0] RF_ADDR,
    output logic              RF_IN,
    output logic              RF_RW,
    input  logic              RF_OUT,
    output logic              BUSY
);

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;

    // Read wait counter terminal value; RD_LAT is limited to 0..3.
    localparam logic [1:0] LAT = 2'(RD_LAT);

    // Last entry of the clear sweep.
    localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_CLEAR,
        S_RESP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [1:0]        cnt;
    logic [1:0]        cnt_nxt;
    logic              req_ready_nxt;
    logic              rsp_valid_nxt;
    logic              rsp_data_nxt;
    logic              rsp_err_nxt;
    logic [ADDR_W-1:0] rf_addr_nxt;
    logic              rf_in_nxt;
    logic              rf_rw_nxt;

    // Next-state and next-output decode; every output is computed here and
    // registered below so the register-file pins never glitch.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_ready_nxt = REQ_READY;
        rsp_valid_nxt = RSP_VALID;
        rsp_data_nxt  = RSP_DATA;
        rsp_err_nxt   = RSP_ERR;
        rf_addr_nxt   = RF_ADDR;
        rf_in_nxt     = 1'b0;
        rf_rw_nxt     = 1'b0;

        case (state)
            S_IDLE: begin
                req_ready_nxt = 1'b1;
                rsp_valid_nxt = 1'b0;
                rsp_data_nxt  = 1'b0;
                rsp_err_nxt   = 1'b0;
                if (REQ_VALID && REQ_READY) begin
                    req_ready_nxt = 1'b0;
                    case (REQ_OP)
                        OP_RD: begin
                            state_nxt   = S_READ;
                            rf_addr_nxt = REQ_ADDR;
                            cnt_nxt     = 2'd0;
                        end
                        OP_WR: begin
                            state_nxt   = S_WRITE;
                            rf_addr_nxt = REQ_ADDR;
                            rf_in_nxt   = REQ_DATA;
                            rf_rw_nxt   = 1'b1;
                        end
                        OP_CLR: begin
                            state_nxt   = S_CLEAR;
                            rf_addr_nxt = '0;
                            rf_rw_nxt   = 1'b1;
                        end
                        default: begin
                            state_nxt     = S_RESP;
                            rsp_valid_nxt = 1'b1;
                            rsp_err_nxt   = 1'b1;
                        end
                    endcase
                end
            end

            S_WRITE: begin
                state_nxt     = S_RESP;
                rsp_valid_nxt = 1'b1;
                rsp_data_nxt  = 1'b0;
                rsp_err_nxt   = 1'b0;
            end

            S_READ: begin
                if (cnt == LAT) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = RF_OUT;
                    rsp_err_nxt   = 1'b0;
                end else begin
                    cnt_nxt = cnt + 2'd1;
                end
            end

            S_CLEAR: begin
                if (RF_ADDR == LAST) begin
                    state_nxt     = S_RESP;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = 1'b0;
                    rsp_err_nxt   = 1'b0;
                end else begin
                    rf_addr_nxt = RF_ADDR + 1'b1;
                    rf_rw_nxt   = 1'b1;
                end
            end

            S_RESP: begin
                req_ready_nxt = 1'b0;
                if (RSP_READY) begin
                    state_nxt     = S_IDLE;
                    rsp_valid_nxt = 1'b0;
                    rsp_data_nxt  = 1'b0;
                    rsp_err_nxt   = 1'b0;
                    req_ready_nxt = 1'b1;
                end
            end

            default: begin
                state_nxt     = S_IDLE;
                rsp_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            cnt       <= 2'd0;
            REQ_READY <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_DATA  <= 1'b0;
            RSP_ERR   <= 1'b0;
            RF_ADDR   <= '0;
            RF_IN     <= 1'b0;
            RF_RW     <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            REQ_READY <= req_ready_nxt;
            RSP_VALID <= rsp_valid_nxt;
            RSP_DATA  <= rsp_data_nxt;
            RSP_ERR   <= rsp_err_nxt;
            RF_ADDR   <= rf_addr_nxt;
            RF_IN     <= rf_in_nxt;
            RF_RW     <= rf_rw_nxt;
            BUSY      <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_wrired_master.sv
// tb_wrired_master: table-driven bench with a response scoreboard and a
// behavioural 4-entry register file behind the master's pins.
module tb_wrired_master;

    localparam int ADDR_W = 2;
    localparam int RD_LAT = 0;
    localparam int DEPTH  = 4;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              REQ_VALID = 1'b0;
    logic              REQ_READY;
    logic [1:0]        REQ_OP = 2'b00;
    logic [ADDR_W-1:0] REQ_ADDR = '0;
    logic              REQ_DATA = 1'b0;
    logic              RSP_VALID;
    logic              RSP_READY = 1'b0;
    logic              RSP_DATA;
    logic              RSP_ERR;
    logic [ADDR_W-1:0] RF_ADDR;
    logic              RF_IN;
    logic              RF_RW;
    logic              RF_OUT;
    logic              BUSY;

    always #5 CLK = ~CLK;

    wrired_master #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .REQ_VALID(REQ_VALID),
        .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP),
        .REQ_ADDR(REQ_ADDR),
        .REQ_DATA(REQ_DATA),
        .RSP_VALID(RSP_VALID),
        .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA),
        .RSP_ERR(RSP_ERR),
        .RF_ADDR(RF_ADDR),
        .RF_IN(RF_IN),
        .RF_RW(RF_RW),
        .RF_OUT(RF_OUT),
        .BUSY(BUSY)
    );

    // Register file model: write on clock edge, combinational read.
    logic rf_mem [DEPTH];
    assign RF_OUT = rf_mem[RF_ADDR];
    always @(posedge CLK) if (RF_RW === 1'b1) rf_mem[RF_ADDR] <= RF_IN;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    // Pin activity log, sampled just after each edge.
    int         rw_cnt = 0;
    int         in_bad = 0;
    logic [1:0] addr_log [$];
    always begin
        @(posedge CLK);
        #1;
        if (RF_RW === 1'b1) begin
            rw_cnt++;
            addr_log.push_back(RF_ADDR);
            if (RF_IN !== 1'b0) in_bad++;
        end
    end

    typedef struct {
        logic [1:0] op;
        logic [1:0] addr;
        logic       data;
        logic       exp_data;
        logic       exp_err;
    } vec_t;

    typedef struct {
        logic d;
        logic e;
        int   lat;
    } sb_t;

    vec_t tbl [15];
    sb_t  exp_q [$];
    int   pass_cnt = 0;
    int   tot_cnt  = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic int lat_of(input logic [1:0] op);
        case (op)
            2'b00:   return 1 + RD_LAT;
            2'b01:   return 1;
            2'b10:   return DEPTH;
            default: return 0;
        endcase
    endfunction

    function automatic int rw_of(input logic [1:0] op);
        case (op)
            2'b01:   return 1;
            2'b10:   return DEPTH;
            default: return 0;
        endcase
    endfunction

    // Present a request from a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic [1:0] op, input logic [1:0] a,
                          input logic d, output int acc, output bit ok);
        ok = 1'b0;
        REQ_VALID = 1'b1;
        REQ_OP = op;
        REQ_ADDR = a;
        REQ_DATA = d;
        for (int k = 0; k < 20; k++) begin
            if (REQ_READY === 1'b1) begin
                @(posedge CLK);
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (ok) @(negedge CLK);
        else chk("req_accept_timeout", 0, 1);
        acc = cyc;
        REQ_VALID = 1'b0;
    endtask

    // Collect one response and compare it against the scoreboard head.
    task automatic get_rsp(input bit chk_lat, input int acc);
        bit  seen;
        sb_t e;
        seen = 1'b0;
        RSP_READY = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (RSP_VALID === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        if (!seen) begin
            chk("rsp_timeout", 0, 1);
        end else if (exp_q.size() == 0) begin
            chk("sb_underflow", 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_data", RSP_DATA, e.d);
            chk("rsp_err", RSP_ERR, e.e);
            if (chk_lat) chk("rsp_latency", cyc - acc, e.lat);
            chk("busy_in_rsp", BUSY, 1);
            chk("req_ready_in_rsp", REQ_READY, 0);
            @(posedge CLK);
            @(negedge CLK);
        end
        RSP_READY = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int acc;
        bit ok;
        sb_t s;

        tbl[0]  = '{2'b01, 2'd0, 1'b1, 1'b0, 1'b0};
        tbl[1]  = '{2'b00, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{2'b01, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{2'b01, 2'd3, 1'b1, 1'b0, 1'b0};
        tbl[4]  = '{2'b01, 2'd2, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{2'b00, 2'd0, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{2'b00, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[7]  = '{2'b00, 2'd2, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{2'b00, 2'd3, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{2'b10, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{2'b00, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[11] = '{2'b00, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[12] = '{2'b00, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{2'b00, 2'd3, 1'b0, 1'b0, 1'b0};
        tbl[14] = '{2'b11, 2'd1, 1'b1, 1'b0, 1'b1};

        for (int i = 0; i < DEPTH; i++) rf_mem[i] = 1'b0;

        // Held in reset with a write pending: nothing accepted, outputs low.
        RST_N = 1'b0;
        REQ_VALID = 1'b1;
        REQ_OP = 2'b01;
        REQ_ADDR = 2'd0;
        REQ_DATA = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("rst_req_ready", REQ_READY, 0);
            chk("rst_rf_rw", RF_RW, 0);
            chk("rst_rsp_valid", RSP_VALID, 0);
            chk("rst_busy", BUSY, 0);
        end
        chk("rst_rsp_data", RSP_DATA, 0);
        chk("rst_rsp_err", RSP_ERR, 0);
        chk("rst_rf_addr", RF_ADDR, 0);
        chk("rst_rf_in", RF_IN, 0);
        chk("rst_no_write", rf_mem[0], 0);
        REQ_VALID = 1'b0;
        RST_N = 1'b1;
        @(negedge CLK);
        chk("post_rst_req_ready", REQ_READY, 1);
        chk("post_rst_busy", BUSY, 0);

        // Main table: write/read patterns, clear sweep, reserved opcode.
        for (int i = 0; i < 15; i++) begin
            rw_cnt = 0;
            in_bad = 0;
            addr_log.delete();
            do_req(tbl[i].op, tbl[i].addr, tbl[i].data, acc, ok);
            if (ok) begin
                s.d = tbl[i].exp_data;
                s.e = tbl[i].exp_err;
                s.lat = lat_of(tbl[i].op);
                exp_q.push_back(s);
                get_rsp(1'b1, acc);
            end
            chk($sformatf("rw_cycles_%0d", i), rw_cnt, rw_of(tbl[i].op));
            if (tbl[i].op == 2'b10) begin
                chk("clr_len", addr_log.size(), DEPTH);
                for (int j = 0; j < DEPTH && j < addr_log.size(); j++)
                    chk($sformatf("clr_addr_%0d", j), addr_log[j], j);
                chk("clr_rf_in", in_bad, 0);
            end
            chk($sformatf("idle_rsp_valid_%0d", i), RSP_VALID, 0);
            chk($sformatf("idle_req_ready_%0d", i), REQ_READY, 1);
        end

        // Response back-pressure: data and valid hold, no new request taken.
        do_req(2'b01, 2'd2, 1'b1, acc, ok);
        s = '{1'b0, 1'b0, 1};
        exp_q.push_back(s);
        get_rsp(1'b1, acc);
        do_req(2'b00, 2'd2, 1'b0, acc, ok);
        s = '{1'b1, 1'b0, 1 + RD_LAT};
        exp_q.push_back(s);
        REQ_VALID = 1'b1;
        REQ_OP = 2'b01;
        REQ_ADDR = 2'd2;
        REQ_DATA = 1'b0;
        for (int k = 0; k < 10 && RSP_VALID !== 1'b1; k++) @(negedge CLK);
        for (int c = 0; c < 5; c++) begin
            chk("stall_rsp_valid", RSP_VALID, 1);
            chk("stall_rsp_data", RSP_DATA, 1);
            chk("stall_req_ready", REQ_READY, 0);
            @(negedge CLK);
        end
        REQ_VALID = 1'b0;
        get_rsp(1'b0, acc);
        chk("stall_no_extra_write", rf_mem[2], 1);

        // Reset two cycles into a clear sweep: no response, tail untouched.
        for (int a = 0; a < DEPTH; a++) begin
            do_req(2'b01, 2'(a), 1'b1, acc, ok);
            s = '{1'b0, 1'b0, 1};
            exp_q.push_back(s);
            get_rsp(1'b1, acc);
        end
        addr_log.delete();
        do_req(2'b10, 2'd0, 1'b0, acc, ok);
        @(negedge CLK);
        RST_N = 1'b0;
        @(negedge CLK);
        chk("abort_rf_rw", RF_RW, 0);
        chk("abort_rsp_valid", RSP_VALID, 0);
        chk("abort_busy", BUSY, 0);
        chk("abort_clr_len", addr_log.size(), 2);
        RST_N = 1'b1;
        RSP_READY = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK);
            chk("abort_no_rsp", RSP_VALID, 0);
        end
        RSP_READY = 1'b0;
        for (int a = 0; a < DEPTH; a++) begin
            do_req(2'b00, 2'(a), 1'b0, acc, ok);
            s = '{(a >= 2) ? 1'b1 : 1'b0, 1'b0, 1 + RD_LAT};
            exp_q.push_back(s);
            get_rsp(1'b1, acc);
        end

        chk("sb_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
